pwm_compare: RTL and testbench
==============================

// Module: pwm_compare
// PURPOSE
//  Downstream consumer of the free-running up-counter: compares counter value against a
//  programmable duty threshold and drives a registered PWM output. Duty updates arrive over a
//  valid/ready handshake, sit in a one-entry pending slot and take effect only at period start
//  (count == 0), giving glitch-free duty changes. Sits between the counter and the output pin.
// PARAMETERS
//  WIDTH       4   width of counter value; PWM period = 2**WIDTH cycles
//  RESET_DUTY  0   active duty after reset (0..2**WIDTH)
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  nrst         in   1        synchronous active-low reset
//  count        in   WIDTH    counter value (free-running, wraps 2**WIDTH-1 -> 0)
//  duty_in      in   WIDTH+1  requested duty, high cycles per period (0..2**WIDTH)
//  duty_valid   in   1        duty_in valid
//  duty_ready   out  1        pending slot empty, duty_in accepted when valid && ready
//  duty_active  out  WIDTH+1  duty currently applied
//  pwm          out  1        PWM output, registered
// BEHAVIOUR
//  - Reset (nrst==0 at rising clk): pwm=0, duty_active=RESET_DUTY, pending slot emptied
//    (duty_ready=1 next cycle). Reset mid-period discards any pending duty.
//  - duty_ready = !pending_vld (combinational from state only, never from duty_valid).
//  - Accept: duty_valid && duty_ready -> pending <= clamp(duty_in), pending_vld <= 1.
//    Clamp: duty_in > 2**WIDTH stored as 2**WIDTH.
//  - Period start: count == 0 && pending_vld -> duty_active <= pending, pending_vld <= 0.
//    count == 0 with slot empty -> duty_active unchanged.
//  - Simultaneous accept and count == 0 with slot empty: value goes to pending only; applied
//    at the NEXT count == 0 (not the current period).
//  - duty_next = pending if (count==0 && pending_vld) else duty_active.
//  - pwm <= (count < duty_next), zero-extended compare in WIDTH+1 bits. Latency 1 cycle:
//    pwm in cycle n+1 reflects count in cycle n. First cycle of a period uses the new duty.
//  - duty 0 -> pwm constantly 0; duty 2**WIDTH -> constantly 1; duty d -> d high, then
//    2**WIDTH-d low per period.
//  - If count never reaches 0, pending duty is held indefinitely, duty_ready stays 0.
//  - No assumption on count increments; block reacts only to value 0 and the comparison.
// CONFIGURATION
//  PWM_PERIOD_IRQ_EN defined: extra output period_irq (out, 1): registered one-cycle pulse,
//    period_irq <= (count == 0); reset value 0. Asserts every period, update or not.
//  PWM_PERIOD_IRQ_EN undefined: port and logic absent; all other behaviour identical.
// TESTING  (WIDTH=4, RESET_DUTY=0, counter driven from reset)
//  1. reset, write duty 8 before first wrap -> duty_active 8 after next count==0; pwm high
//     for 8 cycles, low for 8, repeating, edges 1 cycle after count 0/8.
//  2. duty 0 then duty 16 -> pwm constant 0 for whole period, then constant 1 for whole
//     period after next wrap.
//  3. duty_in 20 -> duty_active 16 (clamped), pwm constant 1.
//  4. write 4, then hold valid with 12 before wrap -> duty_ready 0, 12 not accepted until
//     wrap applies 4; 12 accepted next cycle, applied at following wrap.
//  5. accept duty 6 in exact cycle count==0 -> current period keeps old duty, 6 applies next.
//  6. nrst low for one edge mid-period with pending 10 -> pwm 0, duty_active 0, duty_ready 1,
//     10 never applied. With PWM_PERIOD_IRQ_EN: period_irq pulses once per 16 cycles, 0 in reset.

Source files
------------

// File: rtl/pwm_compare.sv
// rtl/pwm_compare.sv - duty-threshold PWM comparator with period-aligned duty updates
// Optional feature macro PWM_PERIOD_IRQ_EN adds a registered period_irq pulse on count == 0.
module pwm_compare #(
  parameter int WIDTH      = 4,
  parameter int RESET_DUTY = 0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH:0]   duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic [WIDTH:0]   duty_active,
  output logic             pwm
`ifdef PWM_PERIOD_IRQ_EN
  ,
  output logic             period_irq
`endif
);

  localparam logic [WIDTH:0] FULL_DUTY = (WIDTH+1)'(1) << WIDTH;
  localparam logic [WIDTH:0] RST_DUTY  = (WIDTH+1)'(RESET_DUTY);

  logic [WIDTH:0] active_q, active_d;
  logic [WIDTH:0] pend_q, pend_d;
  logic           pend_vld_q, pend_vld_d;
  logic           pwm_q, pwm_d;
  logic [WIDTH:0] duty_next;
  logic [WIDTH:0] duty_clamped;
  logic           period_start;
  logic           accept;

  // A duty accepted in the same cycle as count == 0 lands in the slot and waits a full period.
  always_comb begin
    period_start = (count == '0);
    accept       = duty_valid && !pend_vld_q;
    duty_clamped = (duty_in > FULL_DUTY) ? FULL_DUTY : duty_in;
    duty_next    = (period_start && pend_vld_q) ? pend_q : active_q;
    active_d     = duty_next;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    if (period_start && pend_vld_q) begin
      pend_vld_d = 1'b0;
    end
    if (accept) begin
      pend_d     = duty_clamped;
      pend_vld_d = 1'b1;
    end
    pwm_d = ({1'b0, count} < duty_next);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      active_q   <= RST_DUTY;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      pwm_q      <= 1'b0;
    end else begin
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      pwm_q      <= pwm_d;
    end
  end

  assign duty_ready  = !pend_vld_q;
  assign duty_active = active_q;
  assign pwm         = pwm_q;

`ifdef PWM_PERIOD_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = period_start;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign period_irq = irq_q;
`endif

endmodule

// File: tb/tb_pwm_compare.sv
// tb/tb_pwm_compare.sv - self-checking bench for pwm_compare (WIDTH=4, RESET_DUTY=0)
// Reference model: active duty plus a one-entry pending queue; PWM from count < applied duty.
module tb_pwm_compare;

  localparam int WIDTH = 4;
  localparam int FULL  = 16;

  logic             clk;
  logic             nrst;
  logic [WIDTH-1:0] count;
  logic [WIDTH:0]   duty_in;
  logic             duty_valid;
  logic             duty_ready;
  logic [WIDTH:0]   duty_active;
  logic             pwm;
`ifdef PWM_PERIOD_IRQ_EN
  logic             period_irq;
`endif

  int tests_run = 0;
  int failed    = 0;

  int m_active;
  int m_q[$];
  bit m_pwm;
  bit m_irq;

  pwm_compare #(.WIDTH(WIDTH), .RESET_DUTY(0)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .count      (count),
    .duty_in    (duty_in),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .duty_active(duty_active),
    .pwm        (pwm)
`ifdef PWM_PERIOD_IRQ_EN
    ,
    .period_irq (period_irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge: update the model from the inputs seen at the edge, then advance the counter.
  task automatic step();
    int  dnext;
    bit  acc;
    acc   = duty_valid && (m_q.size() == 0);
    dnext = (count == 0 && m_q.size() != 0) ? m_q[0] : m_active;
    if (!nrst) begin
      m_pwm    = 1'b0;
      m_irq    = 1'b0;
      m_active = 0;
      m_q.delete();
    end else begin
      m_irq = (count == 0);
      m_pwm = (int'(count) < dnext);
      if (count == 0 && m_q.size() != 0) m_active = m_q.pop_front();
      if (acc) m_q.push_back((int'(duty_in) > FULL) ? FULL : int'(duty_in));
    end
    @(posedge clk);
    #1;
    count = nrst ? count + 4'd1 : 4'd0;
  endtask

  task automatic write_duty(input int d);
    duty_in    = (WIDTH+1)'(d);
    duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
  endtask

  task automatic goto_zero();
    for (int i = 0; i < 16 && count != 0; i++) step();
  endtask

  task automatic test_reset();
    nrst = 1'b0; duty_valid = 1'b0; duty_in = '0; count = '0;
    step();
    step();
    nrst = 1'b1;
    tests_run++; if (pwm !== 1'b0) begin failed++; $display("FAIL reset_pwm got %0b want 0", pwm); end
    tests_run++; if (duty_active !== 5'd0) begin failed++; $display("FAIL reset_duty got %0d want 0", duty_active); end
    tests_run++; if (duty_ready !== 1'b1) begin failed++; $display("FAIL reset_ready got %0b want 1", duty_ready); end
`ifdef PWM_PERIOD_IRQ_EN
    tests_run++; if (period_irq !== 1'b0) begin failed++; $display("FAIL reset_irq got %0b want 0", period_irq); end
`endif
  endtask

  task automatic test_duty_8();
    logic [3:0] prev;
    step();
    tests_run++; if (duty_ready !== 1'b1) begin failed++; $display("FAIL d8_ready got %0b want 1", duty_ready); end
    write_duty(8);
    tests_run++; if (duty_ready !== 1'b0) begin failed++; $display("FAIL d8_pending got %0b want 0", duty_ready); end
    tests_run++; if (duty_active !== 5'd0) begin failed++; $display("FAIL d8_not_yet got %0d want 0", duty_active); end
    goto_zero();
    for (int i = 0; i < 32; i++) begin
      prev = count;
      step();
      tests_run++;
      if (pwm !== (prev < 4'd8)) begin failed++; $display("FAIL d8_pwm cnt %0d got %0b want %0b", prev, pwm, prev < 4'd8); end
    end
    tests_run++; if (duty_active !== 5'd8) begin failed++; $display("FAIL d8_active got %0d want 8", duty_active); end
  endtask

  task automatic test_extremes();
    write_duty(0);
    goto_zero();
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin duty_in = 5'd16; duty_valid = 1'b1; end
      step();
      duty_valid = 1'b0;
      tests_run++; if (pwm !== 1'b0) begin failed++; $display("FAIL d0_pwm i %0d got %0b want 0", i, pwm); end
    end
    for (int i = 0; i < 16; i++) begin
      step();
      tests_run++; if (pwm !== 1'b1) begin failed++; $display("FAIL d16_pwm i %0d got %0b want 1", i, pwm); end
    end
    tests_run++; if (duty_active !== 5'd16) begin failed++; $display("FAIL d16_active got %0d want 16", duty_active); end
  endtask

  task automatic test_clamp();
    write_duty(0);
    goto_zero();
    step();
    write_duty(20);
    goto_zero();
    for (int i = 0; i < 16; i++) begin
      step();
      tests_run++; if (pwm !== 1'b1) begin failed++; $display("FAIL clamp_pwm i %0d got %0b want 1", i, pwm); end
    end
    tests_run++; if (duty_active !== 5'd16) begin failed++; $display("FAIL clamp_active got %0d want 16", duty_active); end
  endtask

  task automatic test_back_to_back();
    goto_zero();
    step();
    write_duty(4);
    duty_in = 5'd12; duty_valid = 1'b1;
    for (int i = 0; i < 16 && count != 0; i++) begin
      tests_run++; if (duty_ready !== 1'b0) begin failed++; $display("FAIL b2b_ready cnt %0d got %0b want 0", count, duty_ready); end
      step();
    end
    tests_run++; if (duty_ready !== 1'b0) begin failed++; $display("FAIL b2b_ready_wrap got %0b want 0", duty_ready); end
    step();
    tests_run++; if (duty_active !== 5'd4) begin failed++; $display("FAIL b2b_apply4 got %0d want 4", duty_active); end
    tests_run++; if (duty_ready !== 1'b1) begin failed++; $display("FAIL b2b_free got %0b want 1", duty_ready); end
    step();
    duty_valid = 1'b0;
    tests_run++; if (duty_ready !== 1'b0) begin failed++; $display("FAIL b2b_acc12 got %0b want 0", duty_ready); end
    tests_run++; if (duty_active !== 5'd4) begin failed++; $display("FAIL b2b_hold4 got %0d want 4", duty_active); end
    tests_run++; if (pwm !== m_pwm) begin failed++; $display("FAIL b2b_pwm got %0b want %0b", pwm, m_pwm); end
    goto_zero();
    step();
    tests_run++; if (duty_active !== 5'd12) begin failed++; $display("FAIL b2b_apply12 got %0d want 12", duty_active); end
  endtask

  task automatic test_accept_at_wrap();
    logic [3:0] prev;
    goto_zero();
    duty_in = 5'd6; duty_valid = 1'b1;
    tests_run++; if (duty_ready !== 1'b1) begin failed++; $display("FAIL wrap_ready got %0b want 1", duty_ready); end
    prev = count;
    step();
    duty_valid = 1'b0;
    tests_run++; if (duty_active !== 5'd12) begin failed++; $display("FAIL wrap_keep got %0d want 12", duty_active); end
    tests_run++; if (duty_ready !== 1'b0) begin failed++; $display("FAIL wrap_pending got %0b want 0", duty_ready); end
    tests_run++; if (pwm !== (prev < 4'd12)) begin failed++; $display("FAIL wrap_pwm0 got %0b want 1", pwm); end
    for (int i = 0; i < 15; i++) begin
      prev = count;
      step();
      tests_run++;
      if (pwm !== (prev < 4'd12)) begin failed++; $display("FAIL wrap_pwm cnt %0d got %0b want %0b", prev, pwm, prev < 4'd12); end
    end
    step();
    tests_run++; if (duty_active !== 5'd6) begin failed++; $display("FAIL wrap_apply6 got %0d want 6", duty_active); end
  endtask

  task automatic test_reset_mid();
    goto_zero();
    for (int i = 0; i < 5; i++) step();
    write_duty(10);
    step();
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    tests_run++; if (pwm !== 1'b0) begin failed++; $display("FAIL rmid_pwm got %0b want 0", pwm); end
    tests_run++; if (duty_active !== 5'd0) begin failed++; $display("FAIL rmid_duty got %0d want 0", duty_active); end
    tests_run++; if (duty_ready !== 1'b1) begin failed++; $display("FAIL rmid_ready got %0b want 1", duty_ready); end
`ifdef PWM_PERIOD_IRQ_EN
    tests_run++; if (period_irq !== 1'b0) begin failed++; $display("FAIL rmid_irq got %0b want 0", period_irq); end
`endif
    for (int i = 0; i < 40; i++) begin
      step();
      tests_run++;
      if (duty_active !== 5'd0 || pwm !== 1'b0) begin
        failed++; $display("FAIL rmid_discard i %0d duty %0d pwm %0b want 0/0", i, duty_active, pwm);
      end
    end
`ifdef PWM_PERIOD_IRQ_EN
    begin
      int pulses = 0;
      for (int i = 0; i < 16; i++) begin step(); pulses += int'(period_irq); end
      tests_run++; if (pulses != 1) begin failed++; $display("FAIL irq_rate got %0d pulses want 1", pulses); end
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      duty_valid = ($urandom_range(0, 3) == 0);
      duty_in    = 5'($urandom_range(0, 31));
      nrst       = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 19) == 0) count = 4'($urandom_range(0, 15));
      tests_run++;
      if (duty_ready !== (m_q.size() == 0)) begin failed++; $display("FAIL rnd_ready i %0d got %0b want %0b", i, duty_ready, m_q.size() == 0); end
      step();
      tests_run++;
      if (pwm !== m_pwm || duty_active !== 5'(m_active)) begin
        failed++; $display("FAIL rnd_out i %0d pwm %0b/%0b duty %0d/%0d", i, pwm, m_pwm, duty_active, m_active);
      end
`ifdef PWM_PERIOD_IRQ_EN
      tests_run++; if (period_irq !== m_irq) begin failed++; $display("FAIL rnd_irq i %0d got %0b want %0b", i, period_irq, m_irq); end
`endif
    end
    nrst = 1'b1;
    duty_valid = 1'b0;
  endtask

  initial begin
    m_active = 0;
    m_pwm = 1'b0;
    m_irq = 1'b0;
    test_reset();
    test_duty_8();
    test_extremes();
    test_clamp();
    test_back_to_back();
    test_accept_at_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
